axis_zmod_adc_dec: RTL and testbench

//  Successor to the Zmod ADC capture core: DDR-captures one Zmod two-channel ADC bus (A on rising, B on falling

---
 rtl/axis_zmod_adc_pkg.sv | 27 ++
 rtl/axis_zmod_adc_acc.sv | 39 +++
 rtl/axis_zmod_adc_dec.sv | 150 +++++++++++++++
 tb/tb_axis_zmod_adc_dec.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_zmod_adc_pkg.sv
// Shared constants and helpers for the Zmod ADC decimating capture core.
package axis_zmod_adc_pkg;

  localparam int unsigned DEC_CFG_WIDTH = 4;

  // Accumulator must hold 2^dec_log2_max full-scale samples without wrapping.
  function automatic int unsigned acc_width(input int unsigned data_width,
                                            input int unsigned dec_log2_max);
    return data_width + dec_log2_max;
  endfunction

  // Each AXIS beat carries two channel lanes, B upper and A lower.
  function automatic int unsigned lane_width(input int unsigned tdata_width);
    return tdata_width / 2;
  endfunction

  // Largest positive two's-complement code for a w-bit sample.
  function automatic int max_code(input int unsigned w);
    return (1 << (w - 1)) - 1;
  endfunction

  // Most negative two's-complement code for a w-bit sample.
  function automatic int min_code(input int unsigned w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/axis_zmod_adc_acc.sv
// One channel of the boxcar averager: accumulate, arithmetic-shift on the last sample, restart.
module axis_zmod_adc_acc
  import axis_zmod_adc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 14,
  parameter int unsigned DEC_LOG2_MAX = 8
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic                            enable,
  input  logic                            last,
  input  logic        [DEC_CFG_WIDTH-1:0] shift,
  input  logic signed [DATA_WIDTH-1:0]    sample,
  output logic signed [DATA_WIDTH-1:0]    result_c
);

  localparam int unsigned ACC_WIDTH = acc_width(DATA_WIDTH, DEC_LOG2_MAX);

  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] sum_c;
  logic signed [ACC_WIDTH-1:0] shifted_c;

  // The block's last sample is folded in combinationally so the result is ready on that same cycle.
  assign sum_c     = acc + ACC_WIDTH'(sample);
  assign shifted_c = sum_c >>> shift;
  assign result_c  = DATA_WIDTH'(shifted_c);

  // Running sum; cleared while disabled and restarted from zero after each block.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      acc <= '0;
    end else if (!enable || last) begin
      acc <= '0;
    end else begin
      acc <= sum_c;
    end
  end

endmodule

// File: rtl/axis_zmod_adc_dec.sv
// Zmod ADC DDR capture, per-channel 2^N boxcar decimation and AXI4-Stream output with sticky status.
module axis_zmod_adc_dec
  import axis_zmod_adc_pkg::*;
#(
  parameter int unsigned ADC_DATA_WIDTH   = 14,
  parameter int unsigned AXIS_TDATA_WIDTH = 32,
  parameter int unsigned DEC_LOG2_MAX     = 8
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [ADC_DATA_WIDTH-1:0]   adc_data,
  input  logic                        cfg_enable,
  input  logic [DEC_CFG_WIDTH-1:0]    cfg_dec_log2,
  input  logic                        cfg_clr,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tvalid,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        sts_overflow,
  output logic [1:0]                  sts_overrange
);

  localparam int unsigned LANE_WIDTH = lane_width(AXIS_TDATA_WIDTH);
  localparam int unsigned CNT_WIDTH  = DEC_LOG2_MAX + 1;

  logic        [ADC_DATA_WIDTH-1:0] iddr_q1;
  logic        [ADC_DATA_WIDTH-1:0] iddr_q2;
  logic signed [ADC_DATA_WIDTH-1:0] cap_a;
  logic signed [ADC_DATA_WIDTH-1:0] cap_b;
  logic signed [ADC_DATA_WIDTH-1:0] res_a_c;
  logic signed [ADC_DATA_WIDTH-1:0] res_b_c;
  logic        [CNT_WIDTH-1:0]      cnt;
  logic        [CNT_WIDTH-1:0]      cnt_mask_c;
  logic        [DEC_CFG_WIDTH-1:0]  n_lat;
  logic        [DEC_CFG_WIDTH-1:0]  n_cfg_c;
  logic        [DEC_CFG_WIDTH-1:0]  n_c;
  logic                             last_c;
  logic                             load_c;
  logic                             drop_c;
  logic        [1:0]                hit_c;

  // Same-edge-pipelined DDR input per bit: rising data re-registered so both halves emerge on one rising edge.
  for (genvar i = 0; i < ADC_DATA_WIDTH; i++) begin : g_iddr
    logic rise_r;
    logic fall_r;
    logic q1_r;
    logic q2_r;

    // Rising-edge capture plus the pipeline stage aligning Q1 with Q2.
    always_ff @(posedge aclk) begin
      rise_r <= adc_data[i];
      q1_r   <= rise_r;
      q2_r   <= fall_r;
    end

    // Falling-edge capture of channel B.
    always_ff @(negedge aclk) begin
      fall_r <= adc_data[i];
    end

    assign iddr_q1[i] = q1_r;
    assign iddr_q2[i] = q2_r;
  end

  // Cap stage: one register on aclk between the IDDR outputs and the datapath.
  always_ff @(posedge aclk) begin
    cap_a <= iddr_q1;
    cap_b <= iddr_q2;
  end

  // Exponent is taken live from the config on a block's first sample and held for the rest of it.
  assign n_cfg_c    = (cfg_dec_log2 > DEC_CFG_WIDTH'(DEC_LOG2_MAX)) ?
                      DEC_CFG_WIDTH'(DEC_LOG2_MAX) : cfg_dec_log2;
  assign n_c        = (cnt == '0) ? n_cfg_c : n_lat;
  assign cnt_mask_c = (CNT_WIDTH'(1) << n_c) - CNT_WIDTH'(1);
  assign last_c     = cfg_enable && (cnt == cnt_mask_c);

  // Shared sample counter and exponent latch for both channels.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cnt   <= '0;
      n_lat <= '0;
    end else if (!cfg_enable) begin
      cnt <= '0;
    end else begin
      if (cnt == '0) begin
        n_lat <= n_cfg_c;
      end
      cnt <= last_c ? '0 : cnt + CNT_WIDTH'(1);
    end
  end

  axis_zmod_adc_acc #(
    .DATA_WIDTH   (ADC_DATA_WIDTH),
    .DEC_LOG2_MAX (DEC_LOG2_MAX)
  ) u_acc_a (
    .aclk     (aclk),
    .areset   (areset),
    .enable   (cfg_enable),
    .last     (last_c),
    .shift    (n_c),
    .sample   (cap_a),
    .result_c (res_a_c)
  );

  axis_zmod_adc_acc #(
    .DATA_WIDTH   (ADC_DATA_WIDTH),
    .DEC_LOG2_MAX (DEC_LOG2_MAX)
  ) u_acc_b (
    .aclk     (aclk),
    .areset   (areset),
    .enable   (cfg_enable),
    .last     (last_c),
    .shift    (n_c),
    .sample   (cap_b),
    .result_c (res_b_c)
  );

  assign load_c = last_c && (!m_axis_tvalid || m_axis_tready);
  assign drop_c = last_c && m_axis_tvalid && !m_axis_tready;

  // Output register: a stalled beat is never overwritten; a result arriving during a stall is dropped.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
    end else if (load_c) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= {LANE_WIDTH'(res_b_c), LANE_WIDTH'(res_a_c)};
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  assign hit_c[0] = cfg_enable && ((32'(cap_a) == max_code(ADC_DATA_WIDTH)) ||
                                   (32'(cap_a) == min_code(ADC_DATA_WIDTH)));
  assign hit_c[1] = cfg_enable && ((32'(cap_b) == max_code(ADC_DATA_WIDTH)) ||
                                   (32'(cap_b) == min_code(ADC_DATA_WIDTH)));

  // Sticky status; a new set event overrides a simultaneous clear.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      sts_overflow  <= 1'b0;
      sts_overrange <= 2'b00;
    end else begin
      sts_overflow  <= drop_c | (sts_overflow & ~cfg_clr);
      sts_overrange <= hit_c | (sts_overrange & {2{~cfg_clr}});
    end
  end

endmodule

// File: tb/tb_axis_zmod_adc_dec.sv
// Scoreboard bench for axis_zmod_adc_dec with a block-average reference model.
module tb_axis_zmod_adc_dec;

  logic        aclk;
  logic        areset;
  logic [13:0] adc_data;
  logic        cfg_enable;
  logic [3:0]  cfg_dec_log2;
  logic        cfg_clr;
  logic        m_axis_tready;
  logic        m_axis_tvalid;
  logic [31:0] m_axis_tdata;
  logic        sts_overflow;
  logic [1:0]  sts_overrange;

  int checks = 0;
  int errors = 0;

  // Values applied at the next drive slot.
  logic        en_n   = 1'b0;
  logic [3:0]  dec_n  = 4'd0;
  logic        rdy_n  = 1'b1;
  logic        clr_n  = 1'b0;
  logic        rst_nx = 1'b1;
  logic [13:0] drv_a  = '0;
  logic [13:0] drv_b  = '0;

  // Reference model state.
  int          pa[3] = '{0, 0, 0};
  int          pb[3] = '{0, 0, 0};
  int          m_cnt = 0;
  int          m_sa  = 0;
  int          m_sb  = 0;
  int          m_n   = 0;
  logic [31:0] exp_q[$];
  bit          exp_vld = 1'b0;
  bit          exp_ovf = 1'b0;
  logic [1:0]  exp_ovr = 2'b00;
  bit          started = 1'b0;
  logic [31:0] last_data = '0;

  axis_zmod_adc_dec dut (
    .aclk          (aclk),
    .areset        (areset),
    .adc_data      (adc_data),
    .cfg_enable    (cfg_enable),
    .cfg_dec_log2  (cfg_dec_log2),
    .cfg_clr       (cfg_clr),
    .m_axis_tready (m_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .sts_overflow  (sts_overflow),
    .sts_overrange (sts_overrange)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int floor_div(input int s, input int d);
    int q;
    q = s / d;
    if ((s % d) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  function automatic bit is_extreme(input int v);
    return (v == 8191) || (v == -8192);
  endfunction

  // One clock of stimulus: controls and A before the rising edge, B before the falling edge.
  task automatic step(input logic [13:0] a, input logic [13:0] b);
    logic was_rst;
    @(negedge aclk);
    #1;
    was_rst       = areset;
    areset        = rst_nx;
    cfg_enable    = en_n;
    cfg_dec_log2  = dec_n;
    m_axis_tready = rdy_n;
    cfg_clr       = clr_n;
    clr_n         = 1'b0;
    adc_data      = a;
    drv_a         = a;
    drv_b         = b;
    if (areset && !was_rst) begin
      #1;
      chk("rst_tvalid_now", 32'(m_axis_tvalid), 32'd0);
      chk("rst_tdata_now", m_axis_tdata, 32'd0);
      chk("rst_ovf_now", 32'(sts_overflow), 32'd0);
    end
    @(posedge aclk);
    #1;
    adc_data = drv_b;
  endtask

  function automatic logic [13:0] rnd_sample();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 14'h1FFF;
    if (r == 1) return 14'h2000;
    return 14'($urandom);
  endfunction

  // Reference model: a sample pair reaches the averager three edges after the edge that sampled A.
  always @(posedge aclk) begin
    int ca, cb, ra, rb, d;
    bit res, drop;
    logic [1:0] set;
    ca = pa[2];
    cb = pb[2];
    pa[2] = pa[1]; pa[1] = pa[0]; pa[0] = int'($signed(drv_a));
    pb[2] = pb[1]; pb[1] = pb[0]; pb[0] = int'($signed(drv_b));
    if (areset) begin
      exp_vld = 1'b0;
      exp_q.delete();
      m_cnt = 0; m_sa = 0; m_sb = 0;
      exp_ovf = 1'b0;
      exp_ovr = 2'b00;
    end else begin
      res = 1'b0;
      set = 2'b00;
      ra = 0;
      rb = 0;
      if (cfg_enable) begin
        set[0] = is_extreme(ca);
        set[1] = is_extreme(cb);
        if (m_cnt == 0) m_n = (cfg_dec_log2 > 4'd8) ? 8 : int'(cfg_dec_log2);
        m_sa += ca;
        m_sb += cb;
        m_cnt++;
        d = 1 << m_n;
        if (m_cnt == d) begin
          ra = floor_div(m_sa, d);
          rb = floor_div(m_sb, d);
          res = 1'b1;
          m_cnt = 0; m_sa = 0; m_sb = 0;
        end
      end else begin
        m_cnt = 0; m_sa = 0; m_sb = 0;
      end
      drop = 1'b0;
      if (res) begin
        if (!exp_vld || m_axis_tready) begin
          exp_q.push_back({16'(rb), 16'(ra)});
          exp_vld = 1'b1;
        end else begin
          drop = 1'b1;
        end
      end else if (exp_vld && m_axis_tready) begin
        exp_vld = 1'b0;
      end
      exp_ovf = drop | (exp_ovf & ~cfg_clr);
      exp_ovr = set | (exp_ovr & {2{~cfg_clr}});
    end
  end

  // Monitor: compares handshake state, popped beats and status once per cycle.
  always @(negedge aclk) begin
    logic [31:0] e;
    #2;
    if (started && !areset) begin
      chk("tvalid", 32'(m_axis_tvalid), 32'(exp_vld));
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat actual=%h expected=none at %0t", m_axis_tdata, $time);
        end else begin
          e = exp_q.pop_front();
          chk("tdata", m_axis_tdata, e);
          last_data = m_axis_tdata;
        end
      end
      chk("sts_overflow", 32'(sts_overflow), 32'(exp_ovf));
      chk("sts_overrange", 32'(sts_overrange), 32'(exp_ovr));
    end
  end

  initial begin
    areset        = 1'b1;
    adc_data      = '0;
    cfg_enable    = 1'b0;
    cfg_dec_log2  = '0;
    cfg_clr       = 1'b0;
    m_axis_tready = 1'b1;

    step(14'd0, 14'd0);
    step(14'd0, 14'd0);
    chk("reset_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("reset_tdata", m_axis_tdata, 32'd0);
    chk("reset_ovf", 32'(sts_overflow), 32'd0);
    chk("reset_ovr", 32'(sts_overrange), 32'd0);
    rst_nx = 1'b0;
    step(14'd0, 14'd0);
    started = 1'b1;

    // N=0 with full-scale codes on both channels.
    en_n = 1'b1; dec_n = 4'd0; rdy_n = 1'b1;
    repeat (12) step(14'h1FFF, 14'h2000);
    chk("n0_fullscale_tdata", last_data, 32'hE000_1FFF);
    chk("n0_overrange", 32'(sts_overrange), 32'd3);

    en_n = 1'b0; clr_n = 1'b1;
    repeat (3) step(14'd0, 14'h3FFC);

    // N=2 ramp on A, constant -4 on B.
    en_n = 1'b1; dec_n = 4'd2;
    for (int i = 0; i < 24; i++) step(14'(i % 4), 14'h3FFC);
    chk("n2_ramp_tdata", last_data, 32'hFFFC_0001);

    // N=1 negative pairs on A (floors toward -inf), positive pairs on B.
    dec_n = 4'd1;
    for (int i = 0; i < 16; i++) step((i % 2) ? 14'h3FFE : 14'h3FFF, (i % 2) ? 14'd4 : 14'd3);
    chk("n1_floor_tdata", last_data, 32'h0003_FFFE);

    // Backpressure at N=0: held beat stays, overflow set, then cleared.
    en_n = 1'b0; clr_n = 1'b1;
    repeat (3) step(14'd0, 14'd0);
    en_n = 1'b1; dec_n = 4'd0;
    for (int i = 0; i < 6; i++) step(14'(i + 10), 14'(i + 20));
    rdy_n = 1'b0;
    for (int i = 0; i < 3; i++) step(14'(i + 40), 14'(i + 50));
    chk("stall_overflow", 32'(sts_overflow), 32'd1);
    chk("stall_tvalid", 32'(m_axis_tvalid), 32'd1);
    rdy_n = 1'b1; en_n = 1'b0; clr_n = 1'b1;
    step(14'd0, 14'd0);
    chk("clr_overflow", 32'(sts_overflow), 32'd0);
    repeat (3) step(14'd0, 14'd0);

    // N=3 with the exponent rewritten mid-block.
    en_n = 1'b1; dec_n = 4'd3;
    for (int i = 0; i < 30; i++) begin
      if (i == 4) dec_n = 4'd1;
      step(rnd_sample(), rnd_sample());
    end

    // Reset in the middle of an N=3 block with a beat stalled at the output.
    dec_n = 4'd3; rdy_n = 1'b0; en_n = 1'b0;
    step(14'd0, 14'd0);
    en_n = 1'b1;
    for (int i = 0; i < 13; i++) step(rnd_sample(), rnd_sample());
    rst_nx = 1'b1;
    step(rnd_sample(), rnd_sample());
    step(rnd_sample(), rnd_sample());
    rst_nx = 1'b0; rdy_n = 1'b1;
    for (int i = 0; i < 20; i++) step(rnd_sample(), rnd_sample());

    // Randomised run: data, exponent, enable, backpressure and clear.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) en_n = ~en_n;
      dec_n = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 4));
      rdy_n = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 49) == 0) clr_n = 1'b1;
      step(rnd_sample(), rnd_sample());
    end

    en_n = 1'b0; rdy_n = 1'b1;
    repeat (6) step(14'd0, 14'd0);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_tvalid", 32'(m_axis_tvalid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
